stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Control sequencer for the centisecond stopwatch datapath (time counter + display register).
//   Synchronises and debounces the four raw push-keys.
//   Runs the IDLE/RUN/PAUSE state machine and divides clk down to the 100 Hz tick.
//   Emits single-cycle count/clear/display-load strobes, so the datapath has no key- or edge-clocked logic.
// PARAMETERS
//   CLK_DIV    500000  clk cycles per centisecond tick (50 MHz -> 100 Hz); must be >= 2
//   DB_CYCLES  250000  consecutive stable cycles before a key level is accepted (5 ms at 50 MHz); >= 1
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   key_n      in   4  raw keys, active-low: [3] clear-all, [2] start/pause/resume, [1] lap-freeze, [0] unfreeze
//   count_inc  out  1  1-cycle pulse: datapath advances time counter by one centisecond
//   count_clr  out  1  1-cycle pulse: datapath zeroes time counter and display register
//   disp_load  out  1  1-cycle pulse: datapath copies time counter into display register
//   state      out  2  00 IDLE, 01 RUN, 10 PAUSE (11 never driven)
//   frozen     out  1  display updates suspended (lap view)
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE; frozen=0; count_inc, count_clr, disp_load = 0.
//     Divider=0; sync flops and debounced levels = 1 (released). All outputs registered.
//   Key input chain, per key:
//     - 2-flop synchroniser.
//     - Debounce: debounced level follows the synced level only after the two differ for DB_CYCLES
//       consecutive cycles. Any re-agreement restarts the count.
//     - Press event: 1-cycle internal pulse in the cycle the debounced level goes 1->0. Releases generate nothing.
//     - Latency: raw edge to press event = 2+DB_CYCLES cycles. Event to state/output change = 1 cycle.
//   FSM, on press events. Priority when events coincide: key3 > key2 > key1 > key0; only the winner acts.
//     key3: any state -> IDLE; count_clr pulse; frozen<=0; divider<=0.
//     key2: IDLE->RUN; RUN->PAUSE; PAUSE->RUN. Divider and frozen are untouched.
//     key1: in RUN only: frozen<=1 and one disp_load pulse (captures the current count). Also re-captures if already frozen.
//     key0: in RUN only: frozen<=0. No immediate disp_load.
//     key1/key0 are ignored in IDLE and PAUSE. frozen keeps its value across PAUSE.
//   Divider:
//     - Counts 0..CLK_DIV-1 only in RUN; holds its value in PAUSE; held at 0 in IDLE.
//     - count_inc pulses in the cycle after the divider is at CLK_DIV-1; the divider wraps to 0.
//     - Consequence: pause/resume never loses partial tick progress.
//   Display load:
//     - disp_load asserts 1 cycle after each count_inc when frozen=0, so the display sees the
//       incremented value.
//     - Key1 capture and tick load in the same cycle merge into a single pulse.
//   Simultaneous events:
//     - Key2 RUN->PAUSE in the wrap cycle: that count_inc still issues.
//     - Key3 in the wrap cycle: count_clr issues, count_inc is suppressed, and the trailing disp_load is suppressed.
//   Counter range and wrap (359999 -> 0) belong to the datapath; this block never inspects the count.
//   rst mid-operation: the reset values above apply next cycle; any in-flight debounce progress is discarded.
// TESTING  (CLK_DIV=4, DB_CYCLES=3)
//   - rst, key_n[2] low from cycle t, held -> press event at t+5, state=01 at t+6.
//     count_inc every 4 cycles thereafter; disp_load exactly 1 cycle after each.
//   - Bounce: key_n[2] low 2 cycles, high 1, low 2, then high -> no event; state stays 00; no strobes.
//   - RUN: key1 press -> one disp_load, frozen=1; next 3 count_inc have no disp_load.
//     key0 press -> frozen=0; the next count_inc is followed by disp_load.
//   - RUN with divider=2: key2 press -> state=10, divider holds 2, no count_inc for 20 cycles.
//     key2 again -> state=01; first count_inc 2 cycles after re-entry.
//   - PAUSE, frozen=1: key3 press -> one count_clr, state=00, frozen=0.
//     Then key1/key0 presses -> no disp_load, frozen stays 0.
//   - RUN: key3+key2 events same cycle as wrap -> count_clr=1, count_inc=0, state=00.
//     Separately, rst mid-RUN -> all outputs 0 and state=00 next cycle.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the centisecond stopwatch datapath.
// Synchronises and debounces four active-low keys, runs the IDLE/RUN/PAUSE FSM,
// divides clk down to the centisecond tick and issues single-cycle datapath strobes.
module stopwatch_ctrl #(
    parameter int unsigned CLK_DIV   = 500000,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic       count_inc,
    output logic       count_clr,
    output logic       disp_load,
    output logic [1:0] state,
    output logic       frozen
);

    localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_t;

    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     lvl_q, lvl_prev_q;
    logic [DbW-1:0] db_cnt_q [4];
    logic [3:0]     press;

    state_t         state_q, state_d;
    logic           frozen_q, frozen_d;
    logic [DivW-1:0] div_q, div_d;
    logic           inc_q, inc_d;
    logic           clr_q, clr_d;
    logic           load_q, load_d;
    logic           wrap;

    // Key chain: 2-flop synchroniser, debounce counter, delayed level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            lvl_q      <= 4'hF;
            lvl_prev_q <= 4'hF;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= key_n;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (db_cnt_q[i] == DbLast) begin
                        lvl_q[i]    <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                    end
                end else begin
                    // Any re-agreement restarts the stability count.
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Press event in the first cycle the debounced level reads low.
    assign press = lvl_prev_q & ~lvl_q;
    assign wrap  = (state_q == StRun) && (div_q == DivLast);

    // Next-state: divider, tick strobes, then prioritised key actions overriding them.
    always_comb begin
        state_d  = state_q;
        frozen_d = frozen_q;
        div_d    = div_q;
        inc_d    = 1'b0;
        clr_d    = 1'b0;
        load_d   = inc_q && !frozen_q;

        case (state_q)
            StRun: begin
                div_d = wrap ? '0 : div_q + DivW'(1);
                inc_d = wrap;
            end
            StPause: div_d = div_q;
            default: div_d = '0;
        endcase

        if (press[3]) begin
            state_d  = StIdle;
            frozen_d = 1'b0;
            div_d    = '0;
            clr_d    = 1'b1;
            inc_d    = 1'b0;
            // Clear zeroes the display, so a pending tick load is pointless.
            load_d   = 1'b0;
        end else if (press[2]) begin
            case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end else if (press[1]) begin
            if (state_q == StRun) begin
                frozen_d = 1'b1;
                load_d   = 1'b1;
            end
        end else if (press[0]) begin
            if (state_q == StRun) frozen_d = 1'b0;
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            frozen_q <= 1'b0;
            div_q    <= '0;
            inc_q    <= 1'b0;
            clr_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frozen_q <= frozen_d;
            div_q    <= div_d;
            inc_q    <= inc_d;
            clr_q    <= clr_d;
            load_q   <= load_d;
        end
    end

    assign count_inc = inc_q;
    assign count_clr = clr_q;
    assign disp_load = load_q;
    assign state     = state_q;
    assign frozen    = frozen_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with CLK_DIV=4, DB_CYCLES=3.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic       count_inc, count_clr, disp_load, frozen;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int incs, loads, clrs;

    stopwatch_ctrl #(
        .CLK_DIV   (4),
        .DB_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .count_inc (count_inc),
        .count_clr (count_clr),
        .disp_load (disp_load),
        .state     (state),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Run n cycles and tally strobes seen.
    task automatic run_count(input int n, output int ni, output int nl, output int nc);
        ni = 0; nl = 0; nc = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            ni += int'(count_inc);
            nl += int'(disp_load);
            nc += int'(count_clr);
        end
    endtask

    // Align to a count_inc cycle (divider just wrapped to 0).
    task automatic wait_inc(input string tag);
        int k;
        k = 0;
        while (count_inc !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(count_inc), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        key_n = 4'hF;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_frozen", 32'(frozen), 0);
        check_eq("rst_inc", 32'(count_inc), 0);
        check_eq("rst_clr", 32'(count_clr), 0);
        check_eq("rst_load", 32'(disp_load), 0);

        // Bounce: 2 low, 1 high, 2 low never reaches 3 stable cycles.
        key_n[2] = 1'b0; tick(); tick();
        key_n[2] = 1'b1; tick();
        key_n[2] = 1'b0; tick(); tick();
        key_n[2] = 1'b1;
        run_count(15, incs, loads, clrs);
        check_eq("bounce_state", 32'(state), 0);
        check_eq("bounce_inc", 32'(incs), 0);
        check_eq("bounce_load", 32'(loads), 0);
        check_eq("bounce_clr", 32'(clrs), 0);

        // Start: state changes 6 cycles after the raw edge.
        key_n[2] = 1'b0;
        repeat (5) tick();
        check_eq("start_pre", 32'(state), 0);
        tick();
        check_eq("start_run", 32'(state), 1);
        key_n[2] = 1'b1;
        repeat (3) tick();
        check_eq("first_inc_early", 32'(count_inc), 0);
        tick();
        check_eq("first_inc", 32'(count_inc), 1);
        check_eq("first_inc_noload", 32'(disp_load), 0);
        tick();
        check_eq("first_load", 32'(disp_load), 1);
        check_eq("first_inc_single", 32'(count_inc), 0);
        run_count(16, incs, loads, clrs);
        check_eq("run_incs", 32'(incs), 4);
        check_eq("run_loads", 32'(loads), 4);

        // Lap freeze.
        key_n[1] = 1'b0;
        repeat (6) tick();
        check_eq("freeze_frozen", 32'(frozen), 1);
        check_eq("freeze_load", 32'(disp_load), 1);
        key_n[1] = 1'b1;
        run_count(16, incs, loads, clrs);
        check_eq("frozen_incs", 32'(incs), 4);
        check_eq("frozen_loads", 32'(loads), 0);
        check_eq("frozen_hold", 32'(frozen), 1);

        // Unfreeze.
        key_n[0] = 1'b0;
        repeat (6) tick();
        check_eq("unfreeze", 32'(frozen), 0);
        key_n[0] = 1'b1;
        run_count(16, incs, loads, clrs);
        check_eq("unfrozen_incs", 32'(incs), 4);
        check_eq("unfrozen_loads", 32'(loads), 4);

        // Pause with divider held at 2.
        wait_inc("sync_pause");
        key_n[2] = 1'b0;
        repeat (6) tick();
        check_eq("pause_state", 32'(state), 2);
        key_n[2] = 1'b1;
        run_count(20, incs, loads, clrs);
        check_eq("pause_incs", 32'(incs), 0);
        check_eq("pause_loads", 32'(loads), 0);
        check_eq("pause_hold", 32'(state), 2);

        // Resume: first tick 2 cycles after re-entry.
        key_n[2] = 1'b0;
        repeat (6) tick();
        check_eq("resume_state", 32'(state), 1);
        check_eq("resume_inc0", 32'(count_inc), 0);
        tick();
        check_eq("resume_inc1", 32'(count_inc), 0);
        tick();
        check_eq("resume_inc2", 32'(count_inc), 1);
        tick();
        check_eq("resume_load", 32'(disp_load), 1);
        key_n[2] = 1'b1;
        repeat (7) tick();

        // Freeze, pause, then clear from PAUSE.
        key_n[1] = 1'b0;
        repeat (6) tick();
        check_eq("freeze2", 32'(frozen), 1);
        key_n[1] = 1'b1;
        repeat (7) tick();
        key_n[2] = 1'b0;
        repeat (6) tick();
        check_eq("pause2_state", 32'(state), 2);
        check_eq("pause2_frozen", 32'(frozen), 1);
        key_n[2] = 1'b1;
        repeat (7) tick();
        key_n[3] = 1'b0;
        repeat (6) tick();
        check_eq("clr_pulse", 32'(count_clr), 1);
        check_eq("clr_state", 32'(state), 0);
        check_eq("clr_frozen", 32'(frozen), 0);
        tick();
        check_eq("clr_single", 32'(count_clr), 0);
        key_n[3] = 1'b1;
        repeat (7) tick();

        // key1/key0 ignored in IDLE.
        key_n[1] = 1'b0;
        run_count(10, incs, loads, clrs);
        check_eq("idle_k1_load", 32'(loads), 0);
        check_eq("idle_k1_frozen", 32'(frozen), 0);
        key_n[1] = 1'b1;
        repeat (7) tick();
        key_n[0] = 1'b0;
        run_count(10, incs, loads, clrs);
        check_eq("idle_k0_load", 32'(loads), 0);
        check_eq("idle_k0_state", 32'(state), 0);
        key_n[0] = 1'b1;
        repeat (7) tick();

        // key3+key2 together in the wrap cycle.
        key_n[2] = 1'b0;
        repeat (6) tick();
        check_eq("run3_state", 32'(state), 1);
        key_n[2] = 1'b1;
        repeat (7) tick();
        wait_inc("sync_wrap");
        tick(); tick();
        key_n[3:2] = 2'b00;
        repeat (6) tick();
        check_eq("wrap_clr", 32'(count_clr), 1);
        check_eq("wrap_noinc", 32'(count_inc), 0);
        check_eq("wrap_state", 32'(state), 0);
        tick();
        check_eq("wrap_noload", 32'(disp_load), 0);
        key_n = 4'hF;
        repeat (7) tick();

        // Reset mid-RUN just before a tick-driven load.
        key_n[2] = 1'b0;
        repeat (6) tick();
        check_eq("run4_state", 32'(state), 1);
        key_n[2] = 1'b1;
        repeat (7) tick();
        wait_inc("sync_rst");
        rst = 1'b1;
        tick();
        check_eq("midrst_state", 32'(state), 0);
        check_eq("midrst_load", 32'(disp_load), 0);
        check_eq("midrst_inc", 32'(count_inc), 0);
        check_eq("midrst_clr", 32'(count_clr), 0);
        rst = 1'b0;
        run_count(12, incs, loads, clrs);
        check_eq("postrst_incs", 32'(incs), 0);
        check_eq("postrst_state", 32'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
